// File: rtl/ledip_axil_regs.sv
// rtl/ledip_axil_regs.sv - AXI4-Lite slave with four RW registers driving blinking board LEDs.
module ledip_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_WIDTH          = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]            LED
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  logic [DW-1:0] regs [4];

  logic          aw_held;
  logic          w_held;
  logic [1:0]    aw_idx_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic [1:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          aw_held_n;
  logic          w_held_n;
  logic          bvalid_n;
  logic          rvalid_n;

  logic [DW-1:0] blink_cnt;
  logic          phase;

  logic          unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Commit once both halves of the write are available, live or held.
  always_comb begin
    wr_idx    = aw_held ? aw_idx_q : S_AXI_AWADDR[3:2];
    wr_data   = w_held ? w_data_q : S_AXI_WDATA;
    wr_strb   = w_held ? w_strb_q : S_AXI_WSTRB;
    commit    = (aw_held || aw_hs) && (w_held || w_hs);
    aw_held_n = !commit && (aw_held || aw_hs);
    w_held_n  = !commit && (w_held || w_hs);
    bvalid_n  = commit || (S_AXI_BVALID && !S_AXI_BREADY);
    rvalid_n  = ar_hs || (S_AXI_RVALID && !S_AXI_RREADY);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx_q      <= 2'd0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      S_AXI_BVALID  <= bvalid_n;
      S_AXI_AWREADY <= !aw_held_n && !bvalid_n;
      S_AXI_WREADY  <= !w_held_n && !bvalid_n;
      S_AXI_RVALID  <= rvalid_n;
      S_AXI_ARREADY <= !rvalid_n;
      if (aw_hs) begin
        aw_idx_q <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      // Nonblocking read of regs gives the pre-write value on a same-edge collision.
      if (ar_hs) begin
        S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
      end
      if (commit) begin
        for (int b = 0; b < SW; b++) begin
          if (wr_strb[b]) begin
            regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // REG2 is the half-period; a write to it restarts the blink from phase 0.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
      LED       <= '0;
    end else begin
      if (regs[2] == '0) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (commit && (wr_idx == 2'd2)) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_cnt >= regs[2] - DW'(1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + DW'(1);
      end
      LED <= regs[0][LED_WIDTH-1:0] ^ (regs[1][LED_WIDTH-1:0] & {LED_WIDTH{phase}});
    end
  end

endmodule
